// File: rtl/mipi_csi_rx_packet_decoder_nlane.sv
// CSI-2 receive packet decoder for 1, 2 or 4 byte lanes: sync hunt,
// header ECC/VC check, payload forwarding and short-packet strobes.
module mipi_csi_rx_packet_decoder_nlane #(
  parameter int         LANES        = 4,
  parameter bit         ECC_CHECK_EN = 1'b1,
  parameter bit         VC_FILTER_EN = 1'b0,
  parameter logic [1:0] VC_ID        = 2'd0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               data_valid_i,
  input  logic [8*LANES-1:0] data_i,
  output logic               output_valid_o,
  output logic [8*LANES-1:0] data_o,
  output logic [LANES-1:0]   byte_en_o,
  output logic [15:0]        packet_length_o,
  output logic [2:0]         packet_type_o,
  output logic [1:0]         virtual_channel_o,
  output logic               frame_start_o,
  output logic               frame_end_o,
  output logic               line_start_o,
  output logic               line_end_o,
  output logic               packet_done_o,
  output logic               ecc_error_o
);
  localparam int W = 8 * LANES;
  localparam logic [15:0] STEP = 16'(LANES);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic ov_q, ov_d;
  logic [W-1:0] data_q, data_d;
  logic [LANES-1:0] be_q, be_d;
  logic [15:0] len_q, len_d;
  logic [2:0] typ_q, typ_d;
  logic [1:0] vc_q, vc_d;
  logic fs_q, fs_d, fe_q, fe_d;
  logic ls_q, ls_d, le_q, le_d;
  logic done_q, done_d, ecc_q, ecc_d;

  logic [31:0] hdr;
  logic hdr_last;
  logic sync_hit;
  logic [7:0] di;
  logic [15:0] wc;
  logic [7:0] ecc_b;
  logic ecc_ok;
  logic vc_ok;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [2:0] type_map(input logic [5:0] dt);
    case (dt)
      6'h2A:   return 3'd0;
      6'h2B:   return 3'd1;
      6'h2C:   return 3'd2;
      6'h2D:   return 3'd3;
      6'h1E:   return 3'd4;
      6'h24:   return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // Narrow lanes shift header words in from the top; lane 0 is earliest.
  if (LANES == 4) begin : g_hdr1
    assign hdr = data_i;
    assign hdr_last = 1'b1;
  end else begin : g_hdrn
    localparam int HW = 4 / LANES;
    logic [31-W:0] sh_q;
    logic [1:0] cnt_q;

    assign hdr = {data_i, sh_q};
    assign hdr_last = (cnt_q == 2'(HW - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        sh_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (data_valid_i) sh_q <= hdr[31:W];
        if (state_q == HEADER && data_valid_i && !hdr_last)
          cnt_q <= cnt_q + 2'd1;
        else
          cnt_q <= 2'd0;
      end
    end
  end

  assign sync_hit = (data_i == {LANES{8'hB8}});
  assign {ecc_b, wc, di} = hdr;
  assign ecc_ok = (ecc_b == {2'b00, ecc6({wc, di})});
  assign vc_ok = !VC_FILTER_EN || (di[7:6] == VC_ID);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ov_d    = 1'b0;
    data_d  = '0;
    be_d    = '0;
    len_d   = len_q;
    typ_d   = typ_q;
    vc_d    = vc_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    done_d  = 1'b0;
    ecc_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_valid_i) state_d = sync_hit ? HEADER : DRAIN;
      end
      HEADER: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end else if (hdr_last) begin
          state_d = DRAIN;
          ecc_d   = !ecc_ok;
          if ((ecc_ok || !ECC_CHECK_EN) && vc_ok) begin
            if (di[5:2] == 4'd0) begin
              unique case (di[1:0])
                2'd0: fs_d = 1'b1;
                2'd1: fe_d = 1'b1;
                2'd2: ls_d = 1'b1;
                2'd3: le_d = 1'b1;
              endcase
            end else if (di[5:4] != 2'd0) begin
              len_d = wc;
              typ_d = type_map(di[5:0]);
              vc_d  = di[7:6];
              if (wc == 16'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = PAYLOAD;
                rem_d   = wc;
              end
            end
          end
        end
      end
      PAYLOAD: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end else begin
          ov_d   = 1'b1;
          data_d = data_i;
          rem_d  = rem_q - STEP;
          if (rem_q <= STEP) begin
            done_d  = 1'b1;
            state_d = DRAIN;
            for (int i = 0; i < LANES; i++)
              be_d[i] = (16'(i) < rem_q);
          end else begin
            be_d = '1;
          end
        end
      end
      DRAIN: begin
        if (!data_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      len_q   <= '0;
      typ_q   <= '0;
      vc_q    <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      done_q  <= 1'b0;
      ecc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      be_q    <= be_d;
      len_q   <= len_d;
      typ_q   <= typ_d;
      vc_q    <= vc_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      done_q  <= done_d;
      ecc_q   <= ecc_d;
    end
  end

  assign output_valid_o    = ov_q;
  assign data_o            = data_q;
  assign byte_en_o         = be_q;
  assign packet_length_o   = len_q;
  assign packet_type_o     = typ_q;
  assign virtual_channel_o = vc_q;
  assign frame_start_o     = fs_q;
  assign frame_end_o       = fe_q;
  assign line_start_o      = ls_q;
  assign line_end_o        = le_q;
  assign packet_done_o     = done_q;
  assign ecc_error_o       = ecc_q;

endmodule
